// File: rtl/conv_kxk_pipe.sv
// conv_kxk_pipe: pipelined KxK signed fixed-point convolution window engine
// Ports: clk, rst (async, active-high); in_valid/kernel_load/row_start qualify col_in,
// one K-row column per beat (row r at [r*DATA_WIDTH +: DATA_WIDTH]); kernel_loaded flags
// a complete kernel; out_valid/data_out/out_sat carry one rounded, saturated result per
// issued window, 3 clk after the issuing beat. Define CONV_KXK_RELU_EN for ReLU output.
module conv_kxk_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 14,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              kernel_load,
  input  logic                              row_start,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] col_in,
  output logic                              kernel_loaded,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              out_sat
);
  localparam int K = KERNEL_SIZE;
  localparam int N = K * K;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int ACC_WIDTH = PW + $clog2(N);
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] KC = CW'(K);
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  logic signed [DATA_WIDTH-1:0] kern [K][K];
  logic signed [DATA_WIDTH-1:0] win  [K][K];
  logic signed [PW-1:0] prod [N];
  logic signed [ACC_WIDTH-1:0] sum, sum_c, rnd;
  logic [CW-1:0] kcnt, fill, fill_nx;
  logic [DATA_WIDTH-1:0] d_nx;
  logic img_beat, ker_beat, last_img, issue, issue_q, v1, v2, pos, sat_nx;
  assign img_beat = in_valid && !kernel_load;
  assign ker_beat = in_valid && kernel_load;
  assign kernel_loaded = kcnt == KC;
  assign fill_nx = row_start ? CW'(1) : (fill == KC ? KC : fill + CW'(1));
  // issue is decided on the post-beat fill; image beats never change the kernel count
  assign issue = img_beat && fill_nx == KC && kernel_loaded;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      kcnt <= '0;
      fill <= '0;
      last_img <= 1'b0;
      issue_q <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      data_out <= '0;
      out_sat <= 1'b0;
    end else begin
      if (ker_beat) kcnt <= last_img ? CW'(1) : (kernel_loaded ? KC : kcnt + CW'(1));
      if (img_beat) fill <= fill_nx;
      if (in_valid) last_img <= !kernel_load;
      issue_q <= issue;
      v1 <= issue_q;
      v2 <= v1;
      out_valid <= v2;
      if (v2) begin
        data_out <= d_nx;
        out_sat <= sat_nx;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      kern <= '{default: '0};
      win <= '{default: '0};
    end else if (in_valid) begin
      for (int c = 0; c < K - 1; c++)
        if (kernel_load) kern[c] <= kern[c+1];
        else win[c] <= win[c+1];
      for (int r = 0; r < K; r++)
        if (kernel_load) kern[K-1][r] <= col_in[r*DATA_WIDTH +: DATA_WIDTH];
        else win[K-1][r] <= col_in[r*DATA_WIDTH +: DATA_WIDTH];
    end
  // S1 reads the registered (post-shift) window one clk after issue, so a kernel
  // beat arriving after an issue cannot disturb that result
  always_ff @(posedge clk) begin
    for (int c = 0; c < K; c++)
      for (int r = 0; r < K; r++)
        prod[c*K+r] <= PW'(kern[c][r]) * PW'(win[c][r]);
    sum <= sum_c;
  end
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) sum_c = sum_c + ACC_WIDTH'(prod[i]);
  end
  assign rnd = (sum + HALF) >>> FRAC_BITS;
  assign pos = rnd > MAXV;
`ifdef CONV_KXK_RELU_EN
  assign d_nx = rnd[ACC_WIDTH-1] ? '0 : (pos ? MAXV[DATA_WIDTH-1:0] : rnd[DATA_WIDTH-1:0]);
  assign sat_nx = pos;
`else
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
  logic neg;
  assign neg = rnd < MINV;
  assign d_nx = pos ? MAXV[DATA_WIDTH-1:0] : (neg ? MINV[DATA_WIDTH-1:0] : rnd[DATA_WIDTH-1:0]);
  assign sat_nx = pos || neg;
`endif
endmodule

// File: doc/conv_kxk_pipe.md
Name: conv_kxk_pipe

Overview:
- Parametrised, fully pipelined KxK signed fixed-point convolution window engine for the CNN accelerator datapath.
- Accepts one kernel column or one image column per beat and keeps a sliding KxK window plus kernel store.
- Produces one rounded, saturated output per window position at full throughput with fixed latency.
- Generalises the 3x3 Q2.14 unit: any K, width and fractional point; explicit fill tracking, output valid and saturation flag.

Parameters:
- DATA_WIDTH, 16, sample/weight/output width, two's complement.
- FRAC_BITS, 14, fractional bits of all operands and the output; legal range 1..DATA_WIDTH-1.
- KERNEL_SIZE, 3, window edge K; legal range 2..7.
- Localparam ACC_WIDTH = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE); the sum never overflows before saturation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  beat qualifier for col_in.
- kernel_load  in  1  with in_valid: 1 = kernel column beat, 0 = image column beat.
- row_start  in  1  with an image beat: that column is the first of a new row.
- col_in  in  KERNEL_SIZE*DATA_WIDTH  column; row r (0 = top) at [r*DATA_WIDTH +: DATA_WIDTH].
- kernel_loaded  out  1  all K kernel columns present.
- out_valid  out  1  data_out valid this cycle (single-cycle strobe per result).
- data_out  out  DATA_WIDTH  convolution result, same Q format as the inputs.
- out_sat  out  1  qualified by out_valid: result was clipped.

Behaviour:
- Reset: kernel, window, fill counters, pipeline valids cleared. kernel_loaded, out_valid, data_out and out_sat all read 0. Reset mid-operation discards in-flight results with no partial output.
- Column shift: on a beat, the target array (kernel or window) shifts left one column and col_in enters column K-1. Column 0 is the oldest.
- Kernel count (0..K, saturating): increments on kernel beats. A kernel beat whose previous beat was an image beat restarts the count at 1. kernel_loaded = (count == K).
- Window fill count (0..K, saturating):
  - An image beat with row_start sets the count to 1.
  - Any other image beat increments the count.
  - Kernel beats do not change the window or the fill count.
- Issue: an image beat issues to the pipeline when, after the beat, fill == K and kernel_loaded == 1. Otherwise the column is stored with no output.
- Pipeline, no stall, one issue per clk:
  - S1: register all K*K products, each 2*DATA_WIDTH signed, using the post-shift window.
  - S2: registered adder-tree sum, sign-extended to ACC_WIDTH.
  - S3: add 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS (round half toward +inf). Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and register into data_out and out_sat.
- Latency: out_valid asserts exactly 3 clk after the issuing beat's edge.
- data_out holds its last value while out_valid is 0.
- A kernel reload during in-flight results affects only results issued after it.

Optional Feature:
- Macro CONV_KXK_RELU_EN.
- Defined: S3 applies ReLU after saturation. Negative results become 0; out_sat reflects positive clipping only.
- Undefined: signed output as above, and negative saturation also sets out_sat.

Test Plan:
- Kernel all 0x4000, row_start + 3 image columns all 0x4000 -> sum 9.0; out_valid 3 clk after the 3rd beat, data_out = 0x7FFF, out_sat = 1.
- Kernel all 0xC000 (-1.0), image all 0x4000 -> data_out = 0x8000, out_sat = 1 (RELU_EN: 0x0000, out_sat = 0).
- Identity kernel (centre 0x4000, rest 0), image centre 0x2000 -> 0x2000, out_sat = 0. A 4th column beat gives a second result one clk later (full throughput).
- Rounding: kernel centre 0x0001, image centre 0x2000, rest 0 -> data_out = 0x0001. Image centre 0xE000 -> data_out = 0x0000.
- Fill and gating:
  - Image beats before kernel_loaded never set out_valid.
  - row_start mid-row suppresses output until 3 new columns have arrived.
  - Interleaving a 2-column kernel reload leaves kernel_loaded = 0 and blocks issue.
- Assert rst with 3 results in flight -> out_valid, data_out, out_sat and kernel_loaded go 0 immediately; no output after release until reload and refill.
